// File: rtl/ex_forward_ctrl_if.sv
// ----------------------------------------------------------------------------
// ex_forward_ctrl_if
// Bundle between decode (master) and the execute-stage forwarding/hazard
// controller (slave).
//   issue*        : decode instruction fields (valid, operands, destination)
//   flush, holdIn : squash request and global pipeline freeze
//   stall         : combinational load-use stall back to decode/fetch
//   selectSrc/Dst : registered operand mux codes for the instruction in EX
//   stallCount    : saturating count of load-use stall cycles
//   wbSlot        : {valid, writes, isLoad, rd} of the WB slot, for observation
// ----------------------------------------------------------------------------
interface ex_forward_ctrl_if #(
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
);
   logic              issueValid;
   logic [REG_AW-1:0] issueSrc;
   logic [REG_AW-1:0] issueDst;
   logic              issueUseSrc;
   logic              issueImmOrReg;
   logic              issueWrites;
   logic [REG_AW-1:0] issueRd;
   logic              issueIsLoad;
   logic              flush;
   logic              holdIn;
   logic              stall;
   logic [1:0]        selectSrc;
   logic [1:0]        selectDst;
   logic [CNT_W-1:0]  stallCount;
   logic [REG_AW+2:0] wbSlot;

   modport master (
      output issueValid, issueSrc, issueDst, issueUseSrc, issueImmOrReg,
             issueWrites, issueRd, issueIsLoad, flush, holdIn,
      input  stall, selectSrc, selectDst, stallCount, wbSlot
   );

   modport slave (
      input  issueValid, issueSrc, issueDst, issueUseSrc, issueImmOrReg,
             issueWrites, issueRd, issueIsLoad, flush, holdIn,
      output stall, selectSrc, selectDst, stallCount, wbSlot
   );
endinterface

// File: rtl/ex_forward_ctrl.sv
// ----------------------------------------------------------------------------
// ex_forward_ctrl
// Hazard and operand-forwarding controller for the execute-stage ALU. Shadows
// the destination tags of the instructions in EX, MEM and WB, registers the
// operand mux codes for the next instruction entering EX, and inserts one
// bubble on a load-use hazard.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ex_forward_ctrl_if slave (issue fields, flush/holdIn in;
//           stall, selectSrc, selectDst, stallCount, wbSlot out)
// Mux codes: 00 register file/immediate, 01 EX/MEM result, 10 MEM/WB result.
// ----------------------------------------------------------------------------
module ex_forward_ctrl #(
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst_n,
   ex_forward_ctrl_if.slave bus
);
   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   typedef struct packed {
      logic              valid;
      logic              writes;
      logic              is_load;
      logic [REG_AW-1:0] rd;
   } slot_t;

   slot_t             e_q, m_q, w_q;
   slot_t             e_d, m_d, w_d;
   slot_t             issue_slot;
   logic [1:0]        sel_src_q, sel_src_d;
   logic [1:0]        sel_dst_q, sel_dst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        src_code, dst_code;
   logic              hazard, stall_c;

   function automatic logic fwd_match(input slot_t s, input logic [REG_AW-1:0] addr);
      return s.valid & s.writes & (s.rd == addr);
   endfunction

   // E is checked before M: it holds the youngest producer of the register.
   function automatic logic [1:0] fwd_code(input logic used, input logic [REG_AW-1:0] addr,
                                           input slot_t e, input slot_t m);
      logic [1:0] code;
      code = SEL_RF;
      if (used) begin
         if (fwd_match(e, addr))
            code = SEL_EX;
         else if (fwd_match(m, addr))
            code = SEL_MEM;
      end
      return code;
   endfunction

   always_comb begin
      src_code = fwd_code(bus.issueUseSrc, bus.issueSrc, e_q, m_q);
      dst_code = fwd_code(bus.issueImmOrReg, bus.issueDst, e_q, m_q);

      // A load in EX cannot forward until it leaves MEM, so a dependent
      // instruction must wait one cycle and then picks it up from M.
      hazard = bus.issueValid & e_q.valid & e_q.is_load & e_q.writes &
               ((bus.issueUseSrc   & (e_q.rd == bus.issueSrc)) |
                (bus.issueImmOrReg & (e_q.rd == bus.issueDst)));
      stall_c = hazard & ~bus.flush & ~bus.holdIn;

      issue_slot = '{valid:   bus.issueValid,
                     writes:  bus.issueWrites,
                     is_load: bus.issueIsLoad,
                     rd:      bus.issueRd};

      e_d       = e_q;
      m_d       = m_q;
      w_d       = w_q;
      sel_src_d = sel_src_q;
      sel_dst_d = sel_dst_q;
      cnt_d     = cnt_q;

      if (!bus.holdIn) begin
         m_d = e_q;
         w_d = m_q;
         if (bus.flush || stall_c) begin
            // Flush drops the decode instruction; stall inserts a bubble.
            e_d       = '0;
            sel_src_d = SEL_RF;
            sel_dst_d = SEL_RF;
            if (stall_c && (cnt_q != {CNT_W{1'b1}}))
               cnt_d = cnt_q + CNT_W'(1);
         end else begin
            e_d       = issue_slot;
            sel_src_d = bus.issueValid ? src_code : SEL_RF;
            sel_dst_d = bus.issueValid ? dst_code : SEL_RF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q       <= '0;
         m_q       <= '0;
         w_q       <= '0;
         sel_src_q <= SEL_RF;
         sel_dst_q <= SEL_RF;
         cnt_q     <= '0;
      end else begin
         e_q       <= e_d;
         m_q       <= m_d;
         w_q       <= w_d;
         sel_src_q <= sel_src_d;
         sel_dst_q <= sel_dst_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.stall      = stall_c;
   assign bus.selectSrc  = sel_src_q;
   assign bus.selectDst  = sel_dst_q;
   assign bus.stallCount = cnt_q;
   // WB does not feed forwarding (register file writes before it reads);
   // it is exported only so the pipeline tail can be observed.
   assign bus.wbSlot     = w_q;
endmodule

// File: tb/tb_ex_forward_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_forward_ctrl
// Self-checking bench for ex_forward_ctrl: a table of per-cycle issue vectors
// with expected stall and post-edge select/count values (post-edge values go
// through a scoreboard queue), plus hand sequences for counter saturation
// (second instance with a 2-bit counter) and asynchronous reset mid-hazard.
// ----------------------------------------------------------------------------
module tb_ex_forward_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ex_forward_ctrl_if #(.REG_AW(3), .CNT_W(16)) bus ();
   ex_forward_ctrl_if #(.REG_AW(3), .CNT_W(2))  bus2 ();

   ex_forward_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   ex_forward_ctrl #(.REG_AW(3), .CNT_W(2)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   typedef struct {
      logic        valid;
      logic [2:0]  src;
      logic [2:0]  dst;
      logic        use_src;
      logic        imm_or_reg;
      logic        writes;
      logic [2:0]  rd;
      logic        is_load;
      logic        flush;
      logic        hold;
      logic        exp_stall;
      logic [1:0]  exp_ss;
      logic [1:0]  exp_sd;
      logic [15:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic [1:0]  ss;
      logic [1:0]  sd;
      logic [15:0] cnt;
      string       tag;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(input int va, input int sr, input int ds, input int us,
                               input int im, input int wr, input int rd, input int ld,
                               input int fl, input int hd, input int est,
                               input int ess, input int esd, input int ecnt);
      vec_t v;
      v.valid      = va[0];
      v.src        = sr[2:0];
      v.dst        = ds[2:0];
      v.use_src    = us[0];
      v.imm_or_reg = im[0];
      v.writes     = wr[0];
      v.rd         = rd[2:0];
      v.is_load    = ld[0];
      v.flush      = fl[0];
      v.hold       = hd[0];
      v.exp_stall  = est[0];
      v.exp_ss     = ess[1:0];
      v.exp_sd     = esd[1:0];
      v.exp_cnt    = ecnt[15:0];
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.issueValid    = v.valid;
      bus.issueSrc      = v.src;
      bus.issueDst      = v.dst;
      bus.issueUseSrc   = v.use_src;
      bus.issueImmOrReg = v.imm_or_reg;
      bus.issueWrites   = v.writes;
      bus.issueRd       = v.rd;
      bus.issueIsLoad   = v.is_load;
      bus.flush         = v.flush;
      bus.holdIn        = v.hold;
   endtask

   // Called at edge+1: drive, check stall mid-cycle, queue post-edge
   // expectation, take the edge, then pop and compare.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      drive(v);
      #2;
      check({tag, ".stall"}, 32'(bus.stall), 32'(v.exp_stall));
      exp_q.push_back('{ss: v.exp_ss, sd: v.exp_sd, cnt: v.exp_cnt, tag: tag});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({e.tag, ".selectSrc"}, 32'(bus.selectSrc), 32'(e.ss));
      check({e.tag, ".selectDst"}, 32'(bus.selectDst), 32'(e.sd));
      check({e.tag, ".stallCount"}, 32'(bus.stallCount), 32'(e.cnt));
      $display("[TB] %s stall=%0b selectSrc=%0d selectDst=%0d stallCount=%0d",
               e.tag, v.exp_stall, bus.selectSrc, bus.selectDst, bus.stallCount);
   endtask

   task automatic drive2(input logic va, input logic [2:0] sr, input logic us,
                         input logic wr, input logic [2:0] rd, input logic ld);
      bus2.issueValid    = va;
      bus2.issueSrc      = sr;
      bus2.issueDst      = 3'd0;
      bus2.issueUseSrc   = us;
      bus2.issueImmOrReg = 1'b0;
      bus2.issueWrites   = wr;
      bus2.issueRd       = rd;
      bus2.issueIsLoad   = ld;
      bus2.flush         = 1'b0;
      bus2.holdIn        = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t idle;
      idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0);
      drive(idle);
      drive2(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);

      //           va sr ds us im wr rd ld fl hd  st ss sd cnt
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // 0 idle
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0,  0, 0, 0, 0)); // 1 I1 writes R3
      vecs.push_back(mk(1, 3, 0, 1, 0, 1, 4, 0, 0, 0,  0, 1, 0, 0)); // 2 reads R3 -> EX
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 0, 0, 0)); // 3 writes R5
      vecs.push_back(mk(1, 1, 0, 1, 0, 1, 6, 0, 0, 0,  0, 0, 0, 0)); // 4 unrelated
      vecs.push_back(mk(1, 0, 5, 0, 1, 1, 7, 0, 0, 0,  0, 0, 2, 0)); // 5 dst R5 -> MEM
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 0, 0, 0)); // 6 writes R5
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0,  0, 0, 0, 0)); // 7 unrelated
      vecs.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // 8 dst R5 imm -> 00
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 0,  0, 0, 0, 0)); // 9 load R2
      vecs.push_back(mk(1, 2, 0, 1, 0, 1, 3, 0, 0, 0,  1, 0, 0, 1)); // 10 load-use stall
      vecs.push_back(mk(1, 2, 0, 1, 0, 1, 3, 0, 0, 0,  0, 2, 0, 1)); // 11 reissue -> MEM
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1)); // 12 writes R1
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1)); // 13 writes R1 again
      vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0, 0,  0, 1, 1, 1)); // 14 E beats M
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0,  0, 0, 0, 1)); // 15 load R4
      vecs.push_back(mk(1, 0, 4, 0, 1, 1, 5, 0, 1, 0,  0, 0, 0, 1)); // 16 flush on hazard
      vecs.push_back(mk(1, 4, 0, 1, 0, 1, 6, 0, 0, 0,  0, 2, 0, 1)); // 17 load now in M
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, 0, 0, 1)); // 18 load R7
      vecs.push_back(mk(1, 7, 0, 1, 0, 1, 1, 0, 0, 1,  0, 0, 0, 1)); // 19 hold on hazard
      vecs.push_back(mk(1, 7, 0, 1, 0, 1, 1, 0, 0, 1,  0, 0, 0, 1)); // 20 hold
      vecs.push_back(mk(1, 7, 0, 1, 0, 1, 1, 0, 0, 1,  0, 0, 0, 1)); // 21 hold
      vecs.push_back(mk(1, 7, 0, 1, 0, 1, 1, 0, 0, 0,  1, 0, 0, 2)); // 22 stall after hold
      vecs.push_back(mk(1, 7, 0, 1, 0, 1, 1, 0, 0, 0,  0, 2, 0, 2)); // 23 reissue -> MEM
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2, 0, 2)); // 24 hold keeps select
      vecs.push_back(mk(1, 1, 0, 1, 0, 1, 2, 0, 1, 1,  0, 2, 0, 2)); // 25 hold beats flush
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2)); // 26 invalid -> 00
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 0,  0, 0, 0, 2)); // 27 load R2
      vecs.push_back(mk(0, 2, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2)); // 28 invalid: no stall
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0,  0, 0, 0, 2)); // 29 load R3
      vecs.push_back(mk(1, 0, 3, 0, 0, 1, 4, 0, 0, 0,  0, 0, 0, 2)); // 30 imm op: no stall

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset.selectSrc", 32'(bus.selectSrc), 32'd0);
      check("reset.selectDst", 32'(bus.selectDst), 32'd0);
      check("reset.stallCount", 32'(bus.stallCount), 32'd0);
      check("reset.stall", 32'(bus.stall), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], $sformatf("vec%0d", i));

      // Counter saturation on the 2-bit instance: four hazards, count stops at 3.
      drive(idle);
      for (int k = 1; k <= 4; k++) begin
         drive2(1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1);
         @(posedge clk);
         #1;
         drive2(1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0);
         #2;
         check($sformatf("sat%0d.stall", k), 32'(bus2.stall), 32'd1);
         @(posedge clk);
         #1;
         check($sformatf("sat%0d.stallCount", k), 32'(bus2.stallCount),
               (k > 3) ? 32'd3 : 32'(k));
         $display("[TB] sat%0d stallCount=%0d", k, bus2.stallCount);
         @(posedge clk);
         #1;
      end
      drive2(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);

      // Asynchronous reset between edges while a hazard is pending.
      apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 2), "rst_pre0");
      apply(mk(1, 1, 0, 1, 0, 1, 5, 1, 0, 0,  0, 1, 0, 2), "rst_pre1");
      drive(mk(1, 5, 0, 1, 0, 1, 6, 0, 0, 0,  0, 0, 0, 0));
      #2;
      check("rst_mid.stall_before", 32'(bus.stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid.stall", 32'(bus.stall), 32'd0);
      check("rst_mid.selectSrc", 32'(bus.selectSrc), 32'd0);
      check("rst_mid.selectDst", 32'(bus.selectDst), 32'd0);
      check("rst_mid.stallCount", 32'(bus.stallCount), 32'd0);
      $display("[TB] rst_mid stall=%0b selectSrc=%0d stallCount=%0d",
               bus.stall, bus.selectSrc, bus.stallCount);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // First instruction after reset sees no forwarding and no hazard.
      apply(mk(1, 5, 0, 1, 0, 1, 6, 0, 0, 0,  0, 0, 0, 0), "rst_post");

      check("scoreboard.empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ex_forward_ctrl.md
# ex_forward_ctrl

Hazard and operand-forwarding controller for the execute stage ALU. It shadows the destination tags of the three instructions in flight (EX, MEM, WB) and registers the 2-bit `selectSrc`/`selectDst` muxing codes for the next instruction entering EX. It detects load-use hazards and inserts exactly one bubble, and counts stall cycles. It sits between decode and the EX pipeline register, beside the ALU it configures.

## Interface
Parameters:
- `REG_AW`, 3: register address width (8 GPRs, no hardwired zero).
- `CNT_W`, 16: stall counter width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issueValid`  in  1  decode holds a valid instruction.
- `issueSrc`  in  REG_AW  source register of the decode instruction.
- `issueDst`  in  REG_AW  second-operand register of the decode instruction.
- `issueUseSrc`  in  1  instruction reads `issueSrc`.
- `issueImmOrReg`  in  1  1 = operand 2 comes from register `issueDst`; 0 = immediate.
- `issueWrites`  in  1  instruction writes a register.
- `issueRd`  in  REG_AW  register it writes.
- `issueIsLoad`  in  1  instruction is a memory load (result available only after MEM).
- `flush`  in  1  squash the decode instruction and the EX slot (taken branch/jump).
- `holdIn`  in  1  global pipeline freeze (memory wait).
- `stall`  out  1  combinational: decode must hold, fetch must not advance.
- `selectSrc`  out  2  registered operand-1 mux code for the instruction now in EX.
- `selectDst`  out  2  registered operand-2 mux code for the instruction now in EX.
- `stallCount`  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Mux codes: 00 = register file / immediate, 01 = EX/MEM result (`RegSrcFromEx`), 10 = MEM/WB result (`RegSrcFromMem`). 11 is never driven.
- Slots E, M, W each hold {valid, writes, rd, isLoad} for the instruction in EX, MEM and WB.
- Forward match against slot X means: X.valid & X.writes & X.rd == operand address.
- Operand-1 code for the decode instruction:
  - 00 if `issueUseSrc` = 0.
  - Otherwise 01 on a match against E.
  - Otherwise 10 on a match against M.
  - Otherwise 00.
  - E wins over M: it is the youngest producer.
- Operand-2 code: same rule using `issueDst`, applied only when `issueImmOrReg` = 1; else 00.
- Load-use hazard:
  - `issueValid` & E.valid & E.isLoad & E.writes.
  - And E.rd matches a used operand (src with useSrc, dst with immOrReg).
  - `stall` = hazard & !flush & !holdIn.
- Per-edge priority:
  - `holdIn` = 1: every slot, select and counter holds.
  - `flush` = 1: E is cleared; M←E (old), W←M; selects←00; decode instruction is dropped, not loaded.
  - `stall` = 1: E←bubble (valid=0); M←E; W←M; selects←00; `stallCount` increments, saturating at all-ones.
  - Otherwise: E←decode fields (valid=`issueValid`); M←E; W←M; selects←computed codes. If `issueValid` = 0, selects←00.
- After a stall the load sits in M, so the re-evaluated instruction gets code 10 for that operand. No second stall occurs.
- W is kept for visibility and future use only. It does not drive forwarding, because the register file writes first-half and reads second-half.

## Timing
- Reset (asynchronous, while `rst_n` = 0): all slot valid bits 0, `selectSrc` = `selectDst` = 00, `stallCount` = 0. `stall` then evaluates to 0, because E is invalid.
- Reset deasserted mid-stream: the first instruction issued sees no forwarding.
- `stall` is combinational from the issue inputs and slot E, valid in the same cycle. It is asserted for exactly one cycle per load-use hazard unless `holdIn` extends it; while `holdIn` = 1, `stall` = 0 and nothing moves.
- Select latency: codes computed in the decode cycle appear on `selectSrc`/`selectDst` one edge later, aligned with the instruction's EX cycle.
- Simultaneous `flush` and hazard: flush wins, no stall, counter unchanged.
- Simultaneous `holdIn` and `flush`: hold wins, and the flush must be re-presented by its source.

## Test plan
- Back-to-back ALU: I1 writes R3; next cycle I2 reads src R3 → after next edge `selectSrc` = 01, `stall` never asserted.
- Distance-2: I1 writes R5, unrelated I2, then I3 with `issueDst` = R5 and immOrReg = 1 → I3's EX cycle `selectDst` = 10. The same with immOrReg = 0 → `selectDst` = 00.
- Load-use: load writes R2; next instruction reads src R2 → `stall` = 1 for one cycle and `stallCount` 0→1. The following edge gives `selectSrc` = 10 for the re-issued instruction, with `stall` = 0.
- Double producer: E writes R1 and M writes R1; decode reads R1 → code 01, not 10.
- Flush during hazard: load in E, dependent instruction in decode, `flush` = 1 → `stall` = 0, E cleared, counter unchanged, selects 00.
- Reset and hold: `holdIn` = 1 for 3 cycles mid-hazard → outputs and counter frozen. `rst_n` pulled low asynchronously between edges → selects 00, `stallCount` 0 immediately.
